huff_decoder: RTL and testbench

HUFF_DECODER -- requirements
Module: huff_decoder

---
 rtl/huff_dec_pkg.sv | 28 ++
 rtl/huff_dec_match.sv | 16 +
 rtl/huff_decoder.sv | 132 +++++++++++++
 tb/tb_huff_decoder.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/huff_dec_pkg.sv
// Shared widths, FSM state type and table entry layout for the prefix-code decoder.
// Optional overflow error reporting is enabled by defining HUFF_DEC_ERR_EN.
package huff_dec_pkg;

   localparam int unsigned NSYM   = 6;
   localparam int unsigned CODE_W = 8;
   localparam int unsigned LEN_W  = 4;
   localparam int unsigned SYM_W  = 3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_HOLD  = 2'd2
   } state_t;

   typedef struct packed {
      logic [CODE_W-1:0] code;
      logic [CODE_W-1:0] mask;
   } tbl_entry_t;

   // All-ones mask of the given length, right-aligned (len in 0..CODE_W).
   function automatic logic [CODE_W-1:0] len_mask(input logic [LEN_W-1:0] len);
      logic [CODE_W:0] full;
      full = (CODE_W+1)'(1) << len;
      return CODE_W'(full - (CODE_W+1)'(1));
   endfunction

endpackage

// File: rtl/huff_dec_match.sv
// Single-symbol comparator: hits when the post-shift register holds exactly this code.
module huff_match
   import huff_dec_pkg::*;
(
   input  tbl_entry_t        entry,
   input  logic [CODE_W-1:0] sr_next,
   input  logic [LEN_W-1:0]  len_next,
   output logic              hit_c
);

   // An empty mask marks an unused slot and must never hit.
   assign hit_c = (entry.mask != '0)
                && (entry.mask == len_mask(len_next))
                && ((sr_next & entry.mask) == entry.code);

endmodule

// File: rtl/huff_decoder.sv
// Serial prefix-code decoder for a loadable six-symbol table.
// Define HUFF_DEC_ERR_EN to report 8-bit no-match overflow on err.
module huff_decoder
   import huff_dec_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              tbl_load,
   input  logic [CODE_W-1:0] hc1,
   input  logic [CODE_W-1:0] hc2,
   input  logic [CODE_W-1:0] hc3,
   input  logic [CODE_W-1:0] hc4,
   input  logic [CODE_W-1:0] hc5,
   input  logic [CODE_W-1:0] hc6,
   input  logic [CODE_W-1:0] m1,
   input  logic [CODE_W-1:0] m2,
   input  logic [CODE_W-1:0] m3,
   input  logic [CODE_W-1:0] m4,
   input  logic [CODE_W-1:0] m5,
   input  logic [CODE_W-1:0] m6,
   input  logic              bit_in,
   input  logic              bit_valid,
   output logic              bit_ready,
   output logic              sym_valid,
   input  logic              sym_ready,
   output logic [SYM_W-1:0]  sym_out,
   output logic [LEN_W-1:0]  sym_len,
   output logic              err
);

   state_t            state;
   tbl_entry_t        tbl    [NSYM];
   tbl_entry_t        tbl_in [NSYM];
   logic [CODE_W-1:0] sr;
   logic [CODE_W-1:0] sr_next;
   logic [LEN_W-1:0]  len;
   logic [LEN_W-1:0]  len_next;
   logic [NSYM-1:0]   hit;
   logic              any_hit;
   logic [SYM_W-1:0]  hit_sym;
   logic              accept;
   logic              full;

   assign tbl_in[0] = {hc1, m1};
   assign tbl_in[1] = {hc2, m2};
   assign tbl_in[2] = {hc3, m3};
   assign tbl_in[3] = {hc4, m4};
   assign tbl_in[4] = {hc5, m5};
   assign tbl_in[5] = {hc6, m6};

   // A pending symbol blocks input unless it is being consumed this cycle.
   assign bit_ready = !reset && !tbl_load && (state != ST_IDLE)
                   && (!sym_valid || sym_ready);
   assign accept    = bit_valid && bit_ready;
   assign sr_next   = {sr[CODE_W-2:0], bit_in};
   assign len_next  = len + LEN_W'(1);
   assign full      = (len_next == LEN_W'(CODE_W));

   for (genvar g = 0; g < NSYM; g++) begin : g_match
      huff_match u_match (
         .entry    (tbl[g]),
         .sr_next  (sr_next),
         .len_next (len_next),
         .hit_c    (hit[g])
      );
   end

   // Lowest index wins when a malformed table yields several hits.
   always_comb begin
      any_hit = 1'b0;
      hit_sym = '0;
      for (int i = 0; i < NSYM; i++) begin
         if (hit[i] && !any_hit) begin
            any_hit = 1'b1;
            hit_sym = SYM_W'(i + 1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         sr        <= '0;
         len       <= '0;
         sym_valid <= 1'b0;
         sym_out   <= '0;
         sym_len   <= '0;
         for (int i = 0; i < NSYM; i++) tbl[i] <= '0;
      end else if (tbl_load) begin
         // Reload aborts any partial code or pending symbol.
         state     <= ST_SHIFT;
         sr        <= '0;
         len       <= '0;
         sym_valid <= 1'b0;
         sym_out   <= '0;
         sym_len   <= '0;
         for (int i = 0; i < NSYM; i++) tbl[i] <= tbl_in[i];
      end else begin
         if (sym_valid && sym_ready) begin
            sym_valid <= 1'b0;
            state     <= ST_SHIFT;
         end
         if (accept) begin
            if (any_hit) begin
               sym_valid <= 1'b1;
               sym_out   <= hit_sym;
               sym_len   <= len_next;
               sr        <= '0;
               len       <= '0;
               state     <= ST_HOLD;
            end else if (full) begin
               sr  <= '0;
               len <= '0;
            end else begin
               sr  <= sr_next;
               len <= len_next;
            end
         end
      end
   end

`ifdef HUFF_DEC_ERR_EN
   // One-cycle pulse when eight bits accumulate with no matching code.
   always_ff @(posedge clk) begin
      if (reset || tbl_load) err <= 1'b0;
      else                   err <= accept && !any_hit && full;
   end
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_huff_decoder.sv
// Scoreboard bench for huff_decoder: directed scenarios plus randomized tables and streams.
module tb_huff_decoder;

`ifdef HUFF_DEC_ERR_EN
   localparam bit ERR_EXP = 1'b1;
`else
   localparam bit ERR_EXP = 1'b0;
`endif

   typedef struct {
      int sym;
      int len;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset, tbl_load, bit_in, bit_valid, sym_ready;
   logic [7:0] hc [6];
   logic [7:0] m  [6];
   logic       bit_ready, sym_valid, err;
   logic [2:0] sym_out;
   logic [3:0] sym_len;

   int   checks = 0;
   int   errors = 0;
   int   ovf    = 0;
   int   err_seen = 0;
   exp_t expq [$];
   bit   bq   [$];
   logic [7:0] tc [6];
   logic [7:0] tm [6];
   bit   last_acc;

   always #5 clk = ~clk;

   huff_decoder dut (
      .clk(clk), .reset(reset), .tbl_load(tbl_load),
      .hc1(hc[0]), .hc2(hc[1]), .hc3(hc[2]), .hc4(hc[3]), .hc5(hc[4]), .hc6(hc[5]),
      .m1(m[0]), .m2(m[1]), .m3(m[2]), .m4(m[3]), .m5(m[4]), .m6(m[5]),
      .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(bit_ready),
      .sym_valid(sym_valid), .sym_ready(sym_ready),
      .sym_out(sym_out), .sym_len(sym_len), .err(err)
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: bits collected as a string; a symbol matches when the whole string equals its code.
   task automatic model_bit(input bit b);
      int v;
      int n;
      int found;
      bq.push_back(b);
      n = bq.size();
      v = 0;
      foreach (bq[k]) v = v * 2 + int'(bq[k]);
      found = 0;
      for (int i = 0; i < 6; i++) begin
         int l;
         l = $countones(tm[i]);
         if (found == 0 && l != 0 && l == n && int'(tm[i]) == (1 << l) - 1 && int'(tc[i]) == v)
            found = i + 1;
      end
      if (found != 0) begin
         expq.push_back('{found, n});
         bq.delete();
      end else if (n == 8) begin
         ovf++;
         bq.delete();
      end
   endtask

   task automatic cycle(input bit bv, input bit b, input bit rdy);
      @(negedge clk);
      tbl_load  = 1'b0;
      bit_valid = bv;
      bit_in    = b;
      sym_ready = rdy;
      #1;
      last_acc = bit_valid && bit_ready;
      if (last_acc) model_bit(b);
   endtask

   task automatic do_load(input logic [7:0] c [6], input logic [7:0] k [6]);
      @(negedge clk);
      for (int i = 0; i < 6; i++) begin
         hc[i] = c[i];
         m[i]  = k[i];
         tc[i] = c[i];
         tm[i] = k[i];
      end
      tbl_load  = 1'b1;
      bit_valid = 1'b0;
      sym_ready = 1'b0;
      expq.delete();
      bq.delete();
      #1;
      chk("bit_ready_during_load", int'(bit_ready), 0);
   endtask

   // Monitor: compare the presented symbol with the scoreboard head; pop on handshake.
   initial forever begin
      @(negedge clk);
      #2;
      if (!reset && !tbl_load && sym_valid) begin
         if (expq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_symbol actual=%0d expected=none at %0t", sym_out, $time);
         end else begin
            chk("sym_out", int'(sym_out), expq[0].sym);
            chk("sym_len", int'(sym_len), expq[0].len);
            if (sym_ready) void'(expq.pop_front());
         end
      end
   end

   initial forever begin
      @(posedge clk);
      #1;
      if (!reset && err) err_seen++;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] sc [6];
      logic [7:0] sm [6];
      logic [7:0] rc [6];
      logic [7:0] rm [6];
      sc = '{8'h00, 8'h02, 8'h06, 8'h0E, 8'h1E, 8'h1F};
      sm = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h1F};
      for (int i = 0; i < 6; i++) begin
         hc[i] = '0; m[i] = '0; tc[i] = '0; tm[i] = '0;
      end
      reset = 1'b1; tbl_load = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; sym_ready = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_bit_ready", int'(bit_ready), 0);
      chk("rst_sym_valid", int'(sym_valid), 0);
      chk("rst_sym_out",   int'(sym_out), 0);
      chk("rst_sym_len",   int'(sym_len), 0);
      chk("rst_err",       int'(err), 0);
      reset = 1'b0;
      cycle(1'b1, 1'b1, 1'b1);
      chk("idle_no_accept", int'(last_acc), 0);

      // Code 10: symbol 2 one cycle after its last bit.
      do_load(sc, sm);
      cycle(1'b1, 1'b1, 1'b1);
      chk("first_bit_accept", int'(last_acc), 1);
      cycle(1'b1, 1'b0, 1'b0);
      chk("no_early_valid", int'(sym_valid), 0);
      cycle(1'b0, 1'b0, 1'b0);
      chk("lat_valid", int'(sym_valid), 1);
      chk("lat_sym", int'(sym_out), 2);
      chk("lat_len", int'(sym_len), 2);
      cycle(1'b0, 1'b0, 1'b1);

      // Stream 0,11111,110 with free-running consumer.
      foreach (sc[i]) begin end
      begin
         bit s [9];
         s = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
         foreach (s[i]) cycle(1'b1, s[i], 1'b1);
      end
      cycle(1'b0, 1'b0, 1'b1);
      cycle(1'b0, 1'b0, 1'b1);
      chk("stream_drained", expq.size(), 0);

      // Back-pressure: stall on symbol 1, then accept a bit in the releasing cycle.
      cycle(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, 1'b1, 1'b0);
         chk("stall_bit_ready", int'(bit_ready), 0);
         chk("stall_sym_out", int'(sym_out), 1);
      end
      cycle(1'b1, 1'b1, 1'b1);
      chk("release_accept", int'(last_acc), 1);
      cycle(1'b1, 1'b0, 1'b1);
      cycle(1'b0, 1'b0, 1'b1);
      cycle(1'b0, 1'b0, 1'b1);

      // Reload mid-code discards the partial 11.
      cycle(1'b1, 1'b1, 1'b1);
      cycle(1'b1, 1'b1, 1'b1);
      do_load(sc, sm);
      cycle(1'b1, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0);
      chk("abort_valid", int'(sym_valid), 1);
      chk("abort_sym", int'(sym_out), 1);
      cycle(1'b0, 1'b0, 1'b1);

      // Reset while a symbol is pending.
      cycle(1'b1, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0);
      chk("pre_reset_valid", int'(sym_valid), 1);
      @(negedge clk);
      reset = 1'b1; sym_ready = 1'b1; bit_valid = 1'b1;
      expq.delete(); bq.delete();
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("post_reset_valid", int'(sym_valid), 0);
      chk("post_reset_ready", int'(bit_ready), 0);

      // Overflow: all masks 8'hFF, codes 0..5, eight 1s; then eight 0s resync to symbol 1.
      for (int i = 0; i < 6; i++) begin
         rc[i] = 8'(i);
         rm[i] = 8'hFF;
      end
      do_load(rc, rm);
      for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, 1'b1);
      cycle(1'b0, 1'b0, 1'b1);
      chk("ovf_err_pulse", int'(err), int'(ERR_EXP));
      cycle(1'b0, 1'b0, 1'b1);
      chk("ovf_err_clear", int'(err), 0);
      for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 1'b1);
      cycle(1'b0, 1'b0, 1'b0);
      chk("resync_valid", int'(sym_valid), 1);
      chk("resync_len", int'(sym_len), 8);
      cycle(1'b0, 1'b0, 1'b1);

      // Random stream on the reference table.
      do_load(sc, sm);
      for (int n = 0; n < 600; n++)
         cycle(($urandom_range(0, 3) != 0), 1'($urandom), ($urandom_range(0, 4) < 3));

      // Random (possibly malformed or sparse) tables.
      for (int t = 0; t < 4; t++) begin
         for (int i = 0; i < 6; i++) begin
            int l;
            l = $urandom_range(0, 5);
            rm[i] = 8'((1 << l) - 1);
            rc[i] = 8'($urandom) & rm[i];
         end
         do_load(rc, rm);
         for (int n = 0; n < 400; n++)
            cycle(($urandom_range(0, 3) != 0), 1'($urandom), ($urandom_range(0, 4) < 3));
      end

      for (int n = 0; n < 4; n++) cycle(1'b0, 1'b0, 1'b1);
      chk("final_queue_empty", expq.size(), 0);
      chk("err_pulse_count", err_seen, ERR_EXP ? ovf : 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
